// File: rtl/regfile_dumper_if.sv
// Bundle between the dumper, the register file read ports and the debug output stream.
// The master modport is the dumper side of both the read ports and the stream.
interface regfile_dumper_if #(
    parameter int DATA_W = 32
);
    logic [4:0]        ra1;
    logic [4:0]        ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              out_valid;
    logic              out_ready;
    logic [4:0]        out_addr;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output ra1, ra2, out_valid, out_addr, out_data, out_last,
        input  rd1, rd2, out_ready
    );

    modport slave (
        input  ra1, ra2, out_valid, out_addr, out_data, out_last,
        output rd1, rd2, out_ready
    );
endinterface

// File: rtl/regfile_dumper.sv
// Walks the register file two registers per read cycle and streams each one out
// as an (address, data) beat on a valid/ready channel for debug readout.
module regfile_dumper #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    regfile_dumper_if.master bus,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EMIT0,
        S_EMIT1,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_PAIR = 4'(NREGS / 2 - 1);

    state_t            r_state;
    state_t            w_nextState;
    logic [3:0]        r_pair;
    logic [DATA_W-1:0] r_buf0;
    logic [DATA_W-1:0] r_buf1;
    logic              w_xfer;

    assign w_xfer  = bus.out_valid && bus.out_ready;
    assign bus.ra1 = {r_pair, 1'b0};
    assign bus.ra2 = {r_pair, 1'b1};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (start) w_nextState = S_READ;
            S_READ:  w_nextState = S_EMIT0;
            S_EMIT0: if (w_xfer) w_nextState = S_EMIT1;
            S_EMIT1: if (w_xfer) w_nextState = (r_pair == LAST_PAIR) ? S_DONE : S_READ;
            S_DONE:  w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Each pair is snapshotted in its READ cycle, so later writes to it are not seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pair <= '0;
            r_buf0 <= '0;
            r_buf1 <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) r_pair <= '0;
                end
                S_READ: begin
                    r_buf0 <= bus.rd1;
                    r_buf1 <= bus.rd2;
                end
                S_EMIT1: begin
                    if (w_xfer && (r_pair != LAST_PAIR)) r_pair <= r_pair + 4'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Stream outputs decode registered state only, so they hold steady while stalled.
    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_addr  = '0;
        bus.out_data  = '0;
        bus.out_last  = 1'b0;
        busy          = (r_state != S_IDLE);
        done          = (r_state == S_DONE);
        case (r_state)
            S_EMIT0: begin
                bus.out_valid = 1'b1;
                bus.out_addr  = {r_pair, 1'b0};
                bus.out_data  = r_buf0;
            end
            S_EMIT1: begin
                bus.out_valid = 1'b1;
                bus.out_addr  = {r_pair, 1'b1};
                bus.out_data  = r_buf1;
                bus.out_last  = (r_pair == LAST_PAIR);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_dumper.sv
// Scoreboard bench for regfile_dumper: a register file model feeds the read ports,
// expected beats are queued per dump and a negedge monitor checks the stream.
module tb_regfile_dumper;

    localparam int DATA_W = 32;
    localparam int NREGS  = 32;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        last;
        int          atCycle;
    } beat_t;

    typedef struct {
        int          atCycle;
        logic [4:0]  addr;
        logic [31:0] data;
    } write_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic busy;
    logic done;

    logic        outReady = 1'b1;
    logic        we = 1'b0;
    logic [4:0]  wa = '0;
    logic [31:0] wd = '0;
    logic [31:0] rf [NREGS];

    logic [31:0] modelRegs [NREGS];
    beat_t       expQ[$];
    write_t      planQ[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int startEdge = 0;
    int doneCount = 0;
    int lastXferRc = -100;
    int monRc;
    logic        prevStall = 1'b0;
    logic [4:0]  prevAddr;
    logic [31:0] prevData;
    logic        prevLast;
    beat_t       monBeat;

    regfile_dumper_if #(.DATA_W(DATA_W)) bus ();

    regfile_dumper #(.DATA_W(DATA_W), .NREGS(NREGS)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register file environment: r0 reads as zero, one clocked write port.
    always @(posedge clk) if (we && (wa != 5'd0)) rf[wa] <= wd;
    assign bus.rd1       = (bus.ra1 == 5'd0) ? 32'd0 : rf[bus.ra1];
    assign bus.rd2       = (bus.ra2 == 5'd0) ? 32'd0 : rf[bus.ra2];
    assign bus.out_ready = outReady;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        monRc = cyc - startEdge + 1;
        if (reset) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                checkOutput("stall_valid", 64'(bus.out_valid), 64'd1);
                checkOutput("stall_addr", 64'(bus.out_addr), 64'(prevAddr));
                checkOutput("stall_data", 64'(bus.out_data), 64'(prevData));
                checkOutput("stall_last", 64'(bus.out_last), 64'(prevLast));
            end
            if (bus.out_valid) checkOutput("busy_with_valid", 64'(busy), 64'd1);
            if (bus.out_valid && bus.out_ready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_beat: got addr %0d, expected no beat", bus.out_addr);
                end else begin
                    monBeat = expQ.pop_front();
                    checkOutput("beat_addr", 64'(bus.out_addr), 64'(monBeat.addr));
                    checkOutput("beat_data", 64'(bus.out_data), 64'(monBeat.data));
                    checkOutput("beat_last", 64'(bus.out_last), 64'(monBeat.last));
                    if (monBeat.atCycle >= 0)
                        checkOutput("beat_cycle", 64'(monRc), 64'(monBeat.atCycle));
                end
                lastXferRc = monRc;
            end
            prevStall = bus.out_valid && !bus.out_ready;
            prevAddr  = bus.out_addr;
            prevData  = bus.out_data;
            prevLast  = bus.out_last;
            if (done) begin
                doneCount++;
                checkOutput("done_cycle", 64'(monRc), 64'(lastXferRc + 1));
                checkOutput("done_beats_left", 64'(expQ.size()), 64'd0);
            end
        end
    end

    function automatic logic readyFor(input int mode, input int rc);
        case (mode)
            0:       return 1'b1;
            1:       return (rc % 3) == 0;
            2:       return 1'($urandom % 2);
            default: return rc > 101;
        endcase
    endfunction

    task automatic preload(input logic randomVals);
        for (int r = 1; r < NREGS; r++) begin
            we = 1'b1;
            wa = 5'(r);
            wd = randomVals ? $urandom : 32'h1000_0000 + 32'(r);
            modelRegs[r] = wd;
            @(posedge clk);
            #1;
        end
        we = 1'b0;
        modelRegs[0] = '0;
    endtask

    // Runs one dump; a pair is read in cycle 3k+1, so a write issued in cycle c shows up iff c <= 3k.
    task automatic applyStimulus(input int readyMode, input int restartAt, input int resetAt);
        beat_t  e;
        int     rc;
        logic   finished;
        for (int r = 0; r < NREGS; r++) begin
            e.addr    = 5'(r);
            e.data    = modelRegs[r];
            foreach (planQ[i])
                if (planQ[i].addr == 5'(r) && r != 0 && planQ[i].atCycle <= 3 * (r / 2))
                    e.data = planQ[i].data;
            e.last    = (r == NREGS - 1);
            e.atCycle = (readyMode != 0) ? -1 : ((r % 2 == 0) ? 3 * (r / 2) + 2 : 3 * (r / 2) + 3);
            expQ.push_back(e);
        end
        doneCount  = 0;
        lastXferRc = -100;
        start      = 1'b1;
        outReady   = readyFor(readyMode, 0);
        @(posedge clk);
        #1;
        startEdge = cyc;
        start     = 1'b0;
        rc        = 1;
        finished  = 1'b0;
        while (!finished) begin
            outReady = readyFor(readyMode, rc);
            we = 1'b0;
            foreach (planQ[i]) begin
                if (planQ[i].atCycle == rc) begin
                    we = 1'b1;
                    wa = planQ[i].addr;
                    wd = planQ[i].data;
                end
            end
            start = (rc == restartAt);
            if (readyMode == 3 && rc == 60) begin
                checkOutput("hold_valid", 64'(bus.out_valid), 64'd1);
                checkOutput("hold_addr", 64'(bus.out_addr), 64'd0);
                checkOutput("hold_data", 64'(bus.out_data), 64'(modelRegs[0]));
                checkOutput("hold_busy", 64'(busy), 64'd1);
                checkOutput("hold_done_count", 64'(doneCount), 64'd0);
            end
            if (rc == resetAt) begin
                checkOutput("pre_reset_valid", 64'(bus.out_valid), 64'd1);
                reset = 1'b1;
                #1;
                checkOutput("reset_valid", 64'(bus.out_valid), 64'd0);
                checkOutput("reset_busy", 64'(busy), 64'd0);
                checkOutput("reset_done", 64'(done), 64'd0);
                checkOutput("reset_ra2", 64'(bus.ra2), 64'd1);
                expQ.delete();
                @(posedge clk);
                #1;
                reset    = 1'b0;
                finished = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                rc++;
                if (doneCount > 0) begin
                    finished = 1'b1;
                end else if (rc > 400) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL dump_timeout: got no done after %0d cycles, expected done", rc);
                    finished = 1'b1;
                end
            end
        end
        we       = 1'b0;
        start    = 1'b0;
        outReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        if (resetAt < 0) begin
            checkOutput("done_count", 64'(doneCount), 64'd1);
            checkOutput("beats_left", 64'(expQ.size()), 64'd0);
        end else begin
            checkOutput("abandon_no_done", 64'(doneCount), 64'd0);
        end
        checkOutput("idle_busy", 64'(busy), 64'd0);
        foreach (planQ[i]) if (planQ[i].addr != 5'd0) modelRegs[planQ[i].addr] = planQ[i].data;
        planQ.delete();
        expQ.delete();
    endtask

    initial begin
        write_t w;
        int     c;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_ra1", 64'(bus.ra1), 64'd0);
        checkOutput("rst_ra2", 64'(bus.ra2), 64'd1);
        checkOutput("rst_addr", 64'(bus.out_addr), 64'd0);
        checkOutput("rst_data", 64'(bus.out_data), 64'd0);
        checkOutput("rst_last", 64'(bus.out_last), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        preload(1'b0);

        $display("[TB] baseline dump, ready held high");
        applyStimulus(0, -1, -1);
        $display("[TB] dump with ready toggling");
        applyStimulus(1, -1, -1);
        $display("[TB] start pulsed mid-dump");
        applyStimulus(0, 10, -1);

        $display("[TB] coherency: writes to captured and uncaptured pairs");
        w.atCycle = 3; w.addr = 5'd7; w.data = 32'hDEAD_BEEF; planQ.push_back(w);
        w.atCycle = 4; w.addr = 5'd1; w.data = 32'hCAFE_F00D; planQ.push_back(w);
        applyStimulus(0, -1, -1);

        $display("[TB] reset mid-dump then full dump");
        applyStimulus(0, -1, 20);
        applyStimulus(0, -1, -1);

        $display("[TB] sink stalled for 100 cycles on beat 0");
        applyStimulus(3, -1, -1);

        for (int iter = 0; iter < 6; iter++) begin
            preload(1'b1);
            if (iter % 2 == 0) begin
                c = 2;
                for (int k = 0; k < 8; k++) begin
                    c += 1 + int'($urandom % 6);
                    if (c <= 46) begin
                        w.atCycle = c;
                        w.addr    = 5'($urandom % NREGS);
                        w.data    = $urandom;
                        planQ.push_back(w);
                    end
                end
                applyStimulus(0, -1, -1);
            end else begin
                applyStimulus(2, -1, -1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no end of test, expected finish before 1000000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
